// File: rtl/trace_round_ctrl_pkg.sv
// Shared types, constants and scoring helpers for the trace round controller.
package trace_round_ctrl_pkg;

  // Game phases.
  typedef enum logic [2:0] {
    StIdle,
    StShow,
    StClear,
    StPlay,
    StScore,
    StDone
  } state_e;

  // Pattern generator: 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  // Extra points for covering the snitch box.
  localparam int unsigned SnitchBonus = 4;

  // Width of each player's cumulative score.
  localparam int unsigned ScoreW = 8;

  // One LFSR step: shift left, feedback into bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LfsrTaps)};
  endfunction

  // Points for one round: net hits clamped at zero, plus the snitch bonus.
  function automatic logic [5:0] round_gain(input logic [4:0] hits,
                                            input logic [4:0] misses,
                                            input logic       snitch_hit);
    logic [5:0] base;
    base = (hits > misses) ? {1'b0, hits - misses} : 6'd0;
    return base + (snitch_hit ? 6'(SnitchBonus) : 6'd0);
  endfunction

  // Score accumulate that sticks at all-ones instead of wrapping.
  function automatic logic [ScoreW-1:0] sat_add(input logic [ScoreW-1:0] score,
                                                input logic [5:0]        gain);
    logic [ScoreW:0] sum;
    sum = {1'b0, score} + {{(ScoreW - 5){1'b0}}, gain};
    return sum[ScoreW] ? '1 : sum[ScoreW-1:0];
  endfunction

endpackage

// File: rtl/popcount16.sv
// Counts the set bits of a 16-bit mask.
module popcount16 (
  input  logic [15:0] i_data,
  output logic [4:0]  o_count
);

  // Plain adder chain; synthesis folds it into a compressor tree.
  always_comb begin
    o_count = '0;
    for (int i = 0; i < 16; i++) begin
      o_count = o_count + 5'(i_data[i]);
    end
  end

endmodule

// File: rtl/trace_round_ctrl.sv
// Round sequencer for the trace-the-pattern game: shows a pseudo-random target,
// clears the grid, lets players trace, then scores each round.
module trace_round_ctrl
  import trace_round_ctrl_pkg::*;
#(
  parameter logic [31:0] SHOW_CYCLES  = 32'd50_000_000,
  parameter logic [31:0] CLEAR_CYCLES = 32'd10_000_000,
  parameter logic [31:0] PLAY_CYCLES  = 32'd250_000_000,
  parameter logic [3:0]  NUM_ROUNDS   = 4'd8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_two_player_mode,
  input  logic [15:0]       i_traced_p1,
  input  logic [15:0]       i_traced_p2,
  output logic [15:0]       o_displayed_trace,
  output logic [15:0]       o_snitch_location,
  output logic              o_show_trace,
  output logic              o_reset_trace,
  output logic [ScoreW-1:0] o_score_p1,
  output logic [ScoreW-1:0] o_score_p2,
  output logic [3:0]        o_round,
  output logic              o_busy,
  output logic              o_game_over
);

  state_e            r_state;
  logic [31:0]       r_cnt;
  logic [15:0]       r_lfsr;
  logic [15:0]       r_disp;
  logic [15:0]       r_snitch;
  logic              r_show_trace;
  logic              r_reset_trace;
  logic              r_busy;
  logic              r_game_over;
  logic [ScoreW-1:0] r_score_p1;
  logic [ScoreW-1:0] r_score_p2;
  logic [3:0]        r_round;

  logic [15:0]       w_lfsr_next;
  logic [15:0]       w_snitch_next;
  logic [15:0]       w_hit_mask_p1;
  logic [15:0]       w_miss_mask_p1;
  logic [15:0]       w_hit_mask_p2;
  logic [15:0]       w_miss_mask_p2;
  logic [4:0]        w_hits_p1;
  logic [4:0]        w_misses_p1;
  logic [4:0]        w_hits_p2;
  logic [4:0]        w_misses_p2;
  logic [5:0]        w_gain_p1;
  logic [5:0]        w_gain_p2;
  logic              w_match;
  logic [3:0]        w_round_inc;

  // Next pattern and its snitch box, loaded together on every SHOW entry.
  always_comb begin
    w_lfsr_next   = lfsr_next(r_lfsr);
    w_snitch_next = 16'h0001 << w_lfsr_next[15:12];
  end

  // Split each player's trace into on-target and off-target boxes.
  always_comb begin
    w_hit_mask_p1  = i_traced_p1 & r_disp;
    w_miss_mask_p1 = i_traced_p1 & ~r_disp;
    w_hit_mask_p2  = i_traced_p2 & r_disp;
    w_miss_mask_p2 = i_traced_p2 & ~r_disp;
  end

  popcount16 u_pc_hits_p1 (
    .i_data  (w_hit_mask_p1),
    .o_count (w_hits_p1)
  );

  popcount16 u_pc_misses_p1 (
    .i_data  (w_miss_mask_p1),
    .o_count (w_misses_p1)
  );

  popcount16 u_pc_hits_p2 (
    .i_data  (w_hit_mask_p2),
    .o_count (w_hits_p2)
  );

  popcount16 u_pc_misses_p2 (
    .i_data  (w_miss_mask_p2),
    .o_count (w_misses_p2)
  );

  // Round gains, early-finish detection and round advance.
  always_comb begin
    w_gain_p1   = round_gain(w_hits_p1, w_misses_p1, |(i_traced_p1 & r_snitch));
    w_gain_p2   = round_gain(w_hits_p2, w_misses_p2, |(i_traced_p2 & r_snitch));
    w_match     = (i_traced_p1 == r_disp) ||
                  (i_two_player_mode && (i_traced_p2 == r_disp));
    w_round_inc = r_round + 4'd1;
  end

  // Game FSM with phase counter, pattern generator, scores and registered flags.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_lfsr        <= LfsrSeed;
      r_disp        <= '0;
      r_snitch      <= '0;
      r_show_trace  <= 1'b0;
      r_reset_trace <= 1'b0;
      r_busy        <= 1'b0;
      r_game_over   <= 1'b0;
      r_score_p1    <= '0;
      r_score_p2    <= '0;
      r_round       <= '0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (i_start) begin
            r_state      <= StShow;
            r_cnt        <= '0;
            r_lfsr       <= w_lfsr_next;
            r_disp       <= w_lfsr_next;
            r_snitch     <= w_snitch_next;
            r_show_trace <= 1'b1;
            r_busy       <= 1'b1;
            r_game_over  <= 1'b0;
            r_score_p1   <= '0;
            r_score_p2   <= '0;
            r_round      <= '0;
          end
        end
        StShow: begin
          if (r_cnt == SHOW_CYCLES - 32'd1) begin
            r_state       <= StClear;
            r_cnt         <= '0;
            r_show_trace  <= 1'b0;
            r_reset_trace <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        StClear: begin
          if (r_cnt == CLEAR_CYCLES - 32'd1) begin
            r_state       <= StPlay;
            r_cnt         <= '0;
            r_reset_trace <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        StPlay: begin
          // A completed trace ends the phase without waiting for the timeout.
          if (w_match || (r_cnt == PLAY_CYCLES - 32'd1)) begin
            r_state <= StScore;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        StScore: begin
          r_score_p1 <= sat_add(r_score_p1, w_gain_p1);
          if (i_two_player_mode) begin
            r_score_p2 <= sat_add(r_score_p2, w_gain_p2);
          end
          r_round <= w_round_inc;
          r_cnt   <= '0;
          if (w_round_inc == NUM_ROUNDS) begin
            r_state     <= StDone;
            r_busy      <= 1'b0;
            r_game_over <= 1'b1;
          end else begin
            r_state      <= StShow;
            r_lfsr       <= w_lfsr_next;
            r_disp       <= w_lfsr_next;
            r_snitch     <= w_snitch_next;
            r_show_trace <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Output drive straight from registers.
  always_comb begin
    o_displayed_trace = r_disp;
    o_snitch_location = r_snitch;
    o_show_trace      = r_show_trace;
    o_reset_trace     = r_reset_trace;
    o_score_p1        = r_score_p1;
    o_score_p2        = r_score_p2;
    o_round           = r_round;
    o_busy            = r_busy;
    o_game_over       = r_game_over;
  end

endmodule
